clock_reconfig_sequencer: RTL and testbench
===========================================

CLOCK_RECONFIG_SEQUENCER -- requirements
Module: clock_reconfig_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 8: cycle count for which DCM reset outputs are held high.
REQ-002 Parameter TIMEOUT_W, default 16: width of the wait-timeout counter; timeout is 2^TIMEOUT_W-1 cycles.
REQ-003 Parameter MAX_RETRY, default 3: number of full-sequence retries after a timeout.
REQ-004 Ports clk_i in 1, sequencer clock; reset_n_i in 1, asynchronous active-low reset.
REQ-005 Ports start_i in 1, start request; mul_i in 8, div_i in 8, phase_i in 9, requested settings.
REQ-006 Ports busy_o out 1, sequence running; done_o out 1, one-cycle success pulse; error_o out 1, sticky failure flag.
REQ-007 Ports err_code_o out 2: 0 none, 1 clkgen prog timeout, 2 clkgen lock timeout, 3 ADC lock/phase timeout.
REQ-008 Port lock_lost_o out 1: sticky flag, set when either lock drops in IDLE after a success.
REQ-009 Ports clkgen_reset_o, clkgen_load_o out 1; clkgen_mul_o, clkgen_div_o out 8; clkgen_done_i, gen_locked_i in 1.
REQ-010 Ports adc_reset_o out 1; adc_locked_i in 1; phase_o out 9; phase_load_o out 1; phase_done_i in 1.

Function
REQ-011 gen_locked_i, adc_locked_i and clkgen_done_i SHALL each pass through a 2-FF synchroniser; all decisions use the synchronised values.
REQ-012 States: IDLE, GEN_RST, GEN_LOAD, GEN_WAIT_PROG, GEN_WAIT_LOCK, ADC_RST, ADC_WAIT_LOCK, PH_LOAD, PH_WAIT, FAIL.
REQ-013 In IDLE or FAIL, start_i high SHALL latch mul_i/div_i/phase_i, clear error_o, err_code_o, lock_lost_o and the retry count, and enter GEN_RST on the next cycle.
REQ-014 start_i SHALL be ignored when busy_o is high.
REQ-015 busy_o SHALL be high in every state except IDLE and FAIL.
REQ-016 GEN_RST: clkgen_reset_o SHALL be held high for exactly RST_CYCLES cycles, then the FSM enters GEN_LOAD.
REQ-017 GEN_LOAD: clkgen_load_o SHALL pulse for one cycle with clkgen_mul_o/clkgen_div_o stable (latched values), then the FSM enters GEN_WAIT_PROG.
REQ-018 GEN_WAIT_PROG exits to GEN_WAIT_LOCK on the synchronised clkgen_done high.
REQ-019 GEN_WAIT_LOCK exits to ADC_RST on the synchronised gen_locked high.
REQ-020 ADC_RST: adc_reset_o SHALL be held high for RST_CYCLES cycles, then the FSM enters ADC_WAIT_LOCK.
REQ-021 ADC_WAIT_LOCK exits to PH_LOAD on the synchronised adc_locked high.
REQ-022 PH_LOAD: phase_load_o SHALL pulse for one cycle with phase_o stable, then the FSM enters PH_WAIT.
REQ-023 PH_WAIT: phase_done_i high SHALL pulse done_o for one cycle and return the FSM to IDLE.
REQ-024 The timeout counter SHALL clear on every state entry and increment in each wait state.
REQ-025 If the timeout counter saturates in a wait state and retries are below MAX_RETRY, the retry count SHALL increment and the FSM SHALL re-enter GEN_RST.
REQ-026 If retries are exhausted on timeout, the FSM SHALL enter FAIL, set error_o and set err_code_o per REQ-007; PH_WAIT timeout maps to code 3.
REQ-027 A wait condition and a timeout occurring in the same cycle SHALL be resolved as success.
REQ-028 In IDLE after a successful sequence, a deasserted synchronised gen_locked or adc_locked SHALL set lock_lost_o; the block takes no automatic action.
REQ-029 clkgen_mul_o, clkgen_div_o and phase_o SHALL hold the last latched values while idle.

Reset
REQ-030 While reset_n_i is low, the FSM SHALL be in IDLE and all counters and synchronisers SHALL be zero.
REQ-031 Reset values: clkgen_reset_o=1 and adc_reset_o=1 (DCMs held in reset); all other outputs 0, including settings outputs.
REQ-032 Reset asserted mid-sequence SHALL abort immediately, with no pending load pulse.

Structure
REQ-033 State encoding, err_code values and the default parameter constants SHALL live in the shared package clock_ctrl_pkg.
REQ-034 One sub-module, lock_sync (2-FF synchroniser, parameterised width), SHALL be instantiated once for the 3-bit group.
REQ-035 clock_reconfig_sequencer SHALL connect directly to the existing dcm_clkgen_load and dcm_phaseshift_interface ports without glue logic.

Verification
REQ-036 Scenario: start with mul=8, div=4, phase=20; the models return done, lock, lock and phase_done -> one clkgen_load pulse (8/4), one phase_load pulse (20), done_o once, error_o=0.
REQ-037 Scenario: TIMEOUT_W=6 with gen_locked held low -> 4 GEN_RST passes, then FAIL with err_code_o=2 and busy_o=0.
REQ-038 Scenario: adc_locked is delayed to 70 cycles on the first pass, TIMEOUT_W=6 -> one retry, then done_o, retry count 1.
REQ-039 Scenario: start pulsed again during GEN_WAIT_LOCK with mul=3 -> ignored; clkgen_mul_o stays 8.
REQ-040 Scenario: reset_n_i low during ADC_RST -> outputs at reset values within 0 cycles (async); after release, IDLE and no done_o.
REQ-041 Scenario: after success, drop adc_locked_i for 5 cycles -> lock_lost_o=1 after 2 sync cycles; the next start clears it.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared state encoding, error codes and default constants
// for the DCM clock reconfiguration sequencer.
`timescale 1ns/1ps
package clock_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GEN_RST,
        ST_GEN_LOAD,
        ST_GEN_WAIT_PROG,
        ST_GEN_WAIT_LOCK,
        ST_ADC_RST,
        ST_ADC_WAIT_LOCK,
        ST_PH_LOAD,
        ST_PH_WAIT,
        ST_FAIL
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_PROG     = 2'd1,
        ERR_GEN_LOCK = 2'd2,
        ERR_ADC      = 2'd3
    } err_code_t;

    localparam int unsigned DEF_RST_CYCLES = 8;
    localparam int unsigned DEF_TIMEOUT_W  = 16;
    localparam int unsigned DEF_MAX_RETRY  = 3;

    function automatic logic is_wait(input seq_state_t s);
        return (s == ST_GEN_WAIT_PROG) || (s == ST_GEN_WAIT_LOCK) ||
               (s == ST_ADC_WAIT_LOCK) || (s == ST_PH_WAIT);
    endfunction

    function automatic logic is_rst(input seq_state_t s);
        return (s == ST_GEN_RST) || (s == ST_ADC_RST);
    endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchroniser for a group of slow level signals.
`timescale 1ns/1ps
module lock_sync #(
    parameter int unsigned W = 1
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] sync_o
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= async_i;
            r_sync <= r_meta;
        end
    end

    assign sync_o = r_sync;

endmodule

// File: rtl/clock_reconfig_sequencer.sv
// Sequences clock generator programming, ADC DCM reset/lock and phase
// shift, with per-wait timeouts, full-sequence retries and lock monitoring.
`timescale 1ns/1ps
module clock_reconfig_sequencer
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
    parameter int unsigned TIMEOUT_W  = DEF_TIMEOUT_W,
    parameter int unsigned MAX_RETRY  = DEF_MAX_RETRY
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       start_i,
    input  logic [7:0] mul_i,
    input  logic [7:0] div_i,
    input  logic [8:0] phase_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o,
    output logic [1:0] err_code_o,
    output logic       lock_lost_o,
    output logic       clkgen_reset_o,
    output logic       clkgen_load_o,
    output logic [7:0] clkgen_mul_o,
    output logic [7:0] clkgen_div_o,
    input  logic       clkgen_done_i,
    input  logic       gen_locked_i,
    output logic       adc_reset_o,
    input  logic       adc_locked_i,
    output logic [8:0] phase_o,
    output logic       phase_load_o,
    input  logic       phase_done_i
);

    localparam int unsigned CW = $clog2(RST_CYCLES + 1);
    localparam int unsigned RB = $clog2(MAX_RETRY + 1);
    localparam int unsigned RW = (RB > 0) ? RB : 1;
    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    seq_state_t           r_state;
    seq_state_t           w_next;
    logic [2:0]           w_sync;
    logic                 w_done_s;
    logic                 w_alock_s;
    logic                 w_glock_s;
    logic [TIMEOUT_W-1:0] r_tmo;
    logic [CW-1:0]        r_rst_cnt;
    logic [RW-1:0]        r_retry;
    logic [7:0]           r_mul;
    logic [7:0]           r_div;
    logic [8:0]           r_phase;
    logic                 r_gen_rst;
    logic                 r_adc_rst;
    logic                 r_gen_load;
    logic                 r_ph_load;
    logic                 r_done;
    logic                 r_error;
    err_code_t            r_code;
    logic                 r_lock_lost;
    logic                 r_success;
    logic                 w_start;
    logic                 w_cond;
    logic                 w_tmo_hit;
    logic                 w_retry;
    err_code_t            w_fail_code;

    lock_sync #(.W(3)) u_lock_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .async_i   ({clkgen_done_i, adc_locked_i, gen_locked_i}),
        .sync_o    (w_sync)
    );

    assign w_done_s  = w_sync[2];
    assign w_alock_s = w_sync[1];
    assign w_glock_s = w_sync[0];

    assign busy_o  = (r_state != ST_IDLE) && (r_state != ST_FAIL);
    assign w_start = start_i && !busy_o;

    always_comb begin
        w_next      = r_state;
        w_cond      = 1'b0;
        w_fail_code = ERR_NONE;
        unique case (r_state)
            ST_IDLE, ST_FAIL: begin
                if (w_start) w_next = ST_GEN_RST;
            end
            ST_GEN_RST: begin
                if (r_rst_cnt == RST_LAST) w_next = ST_GEN_LOAD;
            end
            ST_GEN_LOAD: w_next = ST_GEN_WAIT_PROG;
            ST_GEN_WAIT_PROG: begin
                w_cond      = w_done_s;
                w_fail_code = ERR_PROG;
                if (w_cond) w_next = ST_GEN_WAIT_LOCK;
            end
            ST_GEN_WAIT_LOCK: begin
                w_cond      = w_glock_s;
                w_fail_code = ERR_GEN_LOCK;
                if (w_cond) w_next = ST_ADC_RST;
            end
            ST_ADC_RST: begin
                if (r_rst_cnt == RST_LAST) w_next = ST_ADC_WAIT_LOCK;
            end
            ST_ADC_WAIT_LOCK: begin
                w_cond      = w_alock_s;
                w_fail_code = ERR_ADC;
                if (w_cond) w_next = ST_PH_LOAD;
            end
            ST_PH_LOAD: w_next = ST_PH_WAIT;
            ST_PH_WAIT: begin
                w_cond      = phase_done_i;
                w_fail_code = ERR_ADC;
                if (w_cond) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        // a condition arriving on the saturation cycle wins over the timeout
        w_tmo_hit = is_wait(r_state) && !w_cond && (r_tmo == '1);
        w_retry   = w_tmo_hit && (r_retry < RETRY_MAX);
        if (w_tmo_hit) w_next = w_retry ? ST_GEN_RST : ST_FAIL;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= ST_IDLE;
            r_tmo       <= '0;
            r_rst_cnt   <= '0;
            r_retry     <= '0;
            r_mul       <= '0;
            r_div       <= '0;
            r_phase     <= '0;
            r_gen_rst   <= 1'b1;
            r_adc_rst   <= 1'b1;
            r_gen_load  <= 1'b0;
            r_ph_load   <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_code      <= ERR_NONE;
            r_lock_lost <= 1'b0;
            r_success   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_gen_rst  <= (w_next == ST_GEN_RST);
            r_adc_rst  <= (w_next == ST_ADC_RST);
            r_gen_load <= (w_next == ST_GEN_LOAD);
            r_ph_load  <= (w_next == ST_PH_LOAD);
            r_done     <= (r_state == ST_PH_WAIT) && phase_done_i;

            if (w_next != r_state) r_tmo <= '0;
            else if (is_wait(r_state)) r_tmo <= r_tmo + 1'b1;

            if (w_next != r_state) r_rst_cnt <= '0;
            else if (is_rst(r_state)) r_rst_cnt <= r_rst_cnt + 1'b1;

            if (w_start) begin
                r_mul       <= mul_i;
                r_div       <= div_i;
                r_phase     <= phase_i;
                r_retry     <= '0;
                r_error     <= 1'b0;
                r_code      <= ERR_NONE;
                r_lock_lost <= 1'b0;
                r_success   <= 1'b0;
            end else begin
                if (w_retry) r_retry <= r_retry + 1'b1;
                if (w_tmo_hit && !w_retry) begin
                    r_error <= 1'b1;
                    r_code  <= w_fail_code;
                end
                if ((r_state == ST_PH_WAIT) && phase_done_i) r_success <= 1'b1;
                if ((r_state == ST_IDLE) && r_success &&
                    !(w_glock_s && w_alock_s)) r_lock_lost <= 1'b1;
            end
        end
    end

    assign done_o         = r_done;
    assign error_o        = r_error;
    assign err_code_o     = r_code;
    assign lock_lost_o    = r_lock_lost;
    assign clkgen_reset_o = r_gen_rst;
    assign clkgen_load_o  = r_gen_load;
    assign clkgen_mul_o   = r_mul;
    assign clkgen_div_o   = r_div;
    assign adc_reset_o    = r_adc_rst;
    assign phase_o        = r_phase;
    assign phase_load_o   = r_ph_load;

endmodule

// File: tb/tb_clock_reconfig_sequencer.sv
// Randomised bench for clock_reconfig_sequencer: DCM models with per-pass
// stall plans, checked against a pass-level outcome model.
`timescale 1ns/1ps
module tb_clock_reconfig_sequencer;

    localparam int RSTC = 8;
    localparam int TW   = 6;
    localparam int MR   = 3;

    logic       clk_i     = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       start_i   = 1'b0;
    logic [7:0] mul_i     = '0;
    logic [7:0] div_i     = '0;
    logic [8:0] phase_i   = '0;
    logic       busy_o;
    logic       done_o;
    logic       error_o;
    logic [1:0] err_code_o;
    logic       lock_lost_o;
    logic       clkgen_reset_o;
    logic       clkgen_load_o;
    logic [7:0] clkgen_mul_o;
    logic [7:0] clkgen_div_o;
    logic       clkgen_done_i = 1'b0;
    logic       gen_locked_i  = 1'b0;
    logic       adc_reset_o;
    logic       adc_locked_i;
    logic [8:0] phase_o;
    logic       phase_load_o;
    logic       phase_done_i  = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    // stall plan per pass: 0 none, 1 prog, 2 gen lock, 3 adc lock, 4 phase
    int plan [4];
    bit adc_drop = 1'b0;
    bit adc_lvl  = 1'b0;

    int n_grst = 0, n_arst = 0, n_gload = 0, n_pload = 0, n_done = 0;
    int q_gw [$];
    int q_aw [$];
    logic [7:0] q_mul [$];
    logic [7:0] q_div [$];
    logic [8:0] q_ph  [$];

    int pass_idx = 0;
    int t_prog = -1, t_lock = -1, t_adc = -1, t_ph = -1;
    int w_g = 0, w_a = 0;
    bit prev_g = 1'b1, prev_a = 1'b1, meas_g = 1'b0, meas_a = 1'b0;
    bit adc_armed = 1'b0;

    assign adc_locked_i = adc_lvl && !adc_drop;

    clock_reconfig_sequencer #(
        .RST_CYCLES (RSTC),
        .TIMEOUT_W  (TW),
        .MAX_RETRY  (MR)
    ) dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .start_i        (start_i),
        .mul_i          (mul_i),
        .div_i          (div_i),
        .phase_i        (phase_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .err_code_o     (err_code_o),
        .lock_lost_o    (lock_lost_o),
        .clkgen_reset_o (clkgen_reset_o),
        .clkgen_load_o  (clkgen_load_o),
        .clkgen_mul_o   (clkgen_mul_o),
        .clkgen_div_o   (clkgen_div_o),
        .clkgen_done_i  (clkgen_done_i),
        .gen_locked_i   (gen_locked_i),
        .adc_reset_o    (adc_reset_o),
        .adc_locked_i   (adc_locked_i),
        .phase_o        (phase_o),
        .phase_load_o   (phase_load_o),
        .phase_done_i   (phase_done_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #3000000;
        $display("FAIL watchdog expired n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int stage_of(input int p);
        if (p >= 1 && p <= 4) return plan[p-1];
        return 0;
    endfunction

    function automatic int rnd_dly();
        return int'($urandom_range(1, 20));
    endfunction

    // DCM / phase-shifter models, sampled and driven on the falling edge
    always @(negedge clk_i) begin
        phase_done_i = 1'b0;
        if (!reset_n_i) begin
            clkgen_done_i = 1'b0;
            gen_locked_i  = 1'b0;
            adc_lvl       = 1'b0;
            t_prog = -1; t_lock = -1; t_adc = -1; t_ph = -1;
            prev_g = 1'b1; prev_a = 1'b1;
            meas_g = 1'b0; meas_a = 1'b0;
            adc_armed = 1'b0;
            pass_idx  = 0;
        end else begin
            if (!busy_o) pass_idx = 0;
            if (clkgen_reset_o) begin
                if (!prev_g) begin
                    pass_idx++; n_grst++; meas_g = 1'b1; w_g = 0;
                end
                w_g++;
                clkgen_done_i = 1'b0; gen_locked_i = 1'b0;
                t_prog = -1; t_lock = -1;
            end else if (prev_g && meas_g) begin
                meas_g = 1'b0; q_gw.push_back(w_g);
            end
            prev_g = clkgen_reset_o;
            if (adc_reset_o) begin
                if (!prev_a) begin
                    n_arst++; meas_a = 1'b1; w_a = 0;
                end
                w_a++;
                adc_lvl = 1'b0; adc_armed = 1'b1; t_adc = -1;
            end else begin
                if (prev_a && meas_a) begin
                    meas_a = 1'b0; q_aw.push_back(w_a);
                end
                if (adc_armed) begin
                    adc_armed = 1'b0;
                    if (stage_of(pass_idx) != 3) t_adc = rnd_dly();
                end
            end
            prev_a = adc_reset_o;
            if (clkgen_load_o) begin
                n_gload++;
                q_mul.push_back(clkgen_mul_o);
                q_div.push_back(clkgen_div_o);
                if (stage_of(pass_idx) != 1) t_prog = rnd_dly();
            end
            if (phase_load_o) begin
                n_pload++;
                q_ph.push_back(phase_o);
                if (stage_of(pass_idx) != 4) t_ph = rnd_dly();
            end
            if (done_o) n_done++;
            if (t_prog == 0) begin
                clkgen_done_i = 1'b1; t_prog = -1;
                if (stage_of(pass_idx) != 2) t_lock = rnd_dly();
            end else if (t_prog > 0) t_prog--;
            if (t_lock == 0) begin
                gen_locked_i = 1'b1; t_lock = -1;
            end else if (t_lock > 0) t_lock--;
            if (t_adc == 0) begin
                adc_lvl = 1'b1; t_adc = -1;
            end else if (t_adc > 0) t_adc--;
            if (t_ph == 0) begin
                phase_done_i = 1'b1; t_ph = -1;
            end else if (t_ph > 0) t_ph--;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic pulse_start(input logic [7:0] m, input logic [7:0] d,
                               input logic [8:0] p);
        @(negedge clk_i);
        mul_i = m; div_i = d; phase_i = p; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk_i);
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_seq(input logic [7:0] m, input logic [7:0] d,
                           input logic [8:0] p, input int p0, input int p1,
                           input int p2, input int p3, input bit mid);
        int passes, code, exp_al, exp_pl;
        int b_grst, b_arst, b_gload, b_pload, b_done, b_gw, b_aw;
        bit succ, ok;
        plan[0] = p0; plan[1] = p1; plan[2] = p2; plan[3] = p3;
        // outcome model: first unstalled pass succeeds, else retry up to MR
        succ = 1'b0; passes = 0; code = 0; exp_al = 0; exp_pl = 0;
        for (int i = 0; i <= MR; i++) begin
            passes++;
            if (plan[i] == 0 || plan[i] >= 3) exp_al++;
            if (plan[i] == 0 || plan[i] == 4) exp_pl++;
            if (plan[i] == 0) begin
                succ = 1'b1;
                break;
            end
            code = (plan[i] == 4) ? 3 : plan[i];
        end
        if (succ) code = 0;
        b_grst = n_grst; b_arst = n_arst; b_gload = n_gload;
        b_pload = n_pload; b_done = n_done;
        b_gw = q_gw.size(); b_aw = q_aw.size();
        pulse_start(m, d, p);
        check("start_busy", busy_o, 1);
        check("start_clears_lost", lock_lost_o, 0);
        check("start_clears_err", error_o, 0);
        if (mid) begin
            for (int k = 0; k < 300 && !clkgen_done_i; k++) tick(1);
            check("mid_reach", clkgen_done_i, 1);
            tick(3);
            pulse_start(8'd3, 8'd9, 9'd7);
            check("mid_mul_hold", clkgen_mul_o, m);
        end
        wait_idle(ok);
        check("finished", ok, 1);
        tick(2);
        check("done_cnt", n_done - b_done, succ ? 1 : 0);
        check("error", error_o, succ ? 0 : 1);
        check("err_code", err_code_o, code);
        check("busy_end", busy_o, 0);
        check("gen_rst_passes", n_grst - b_grst, passes);
        check("gen_loads", n_gload - b_gload, passes);
        check("adc_rst_passes", n_arst - b_arst, exp_al);
        check("ph_loads", n_pload - b_pload, exp_pl);
        check("lock_lost_end", lock_lost_o, 0);
        check("mul_hold", clkgen_mul_o, m);
        check("div_hold", clkgen_div_o, d);
        check("phase_hold", phase_o, p);
        for (int i = b_gload; i < n_gload; i++) begin
            check("load_mul", q_mul[i], m);
            check("load_div", q_div[i], d);
        end
        for (int i = b_pload; i < n_pload; i++) check("load_phase", q_ph[i], p);
        for (int i = b_gw; i < q_gw.size(); i++) check("gen_rst_w", q_gw[i], RSTC);
        for (int i = b_aw; i < q_aw.size(); i++) check("adc_rst_w", q_aw[i], RSTC);
    endtask

    initial begin
        int b_gload, b_pload, b_done;
        bit found;
        reset_n_i = 1'b0;
        tick(3);
        check("rst_ctrl", {busy_o, done_o, error_o, err_code_o, lock_lost_o,
                           clkgen_reset_o, clkgen_load_o, adc_reset_o,
                           phase_load_o}, 32'h00A);
        check("rst_settings", {clkgen_mul_o, clkgen_div_o, phase_o}, 0);
        reset_n_i = 1'b1;
        tick(3);
        check("idle_busy", busy_o, 0);

        run_seq(8'd8, 8'd4, 9'd20, 0, 0, 0, 0, 1'b0);

        check("lost_before", lock_lost_o, 0);
        adc_drop = 1'b1;
        tick(3);
        check("lost_set", lock_lost_o, 1);
        tick(2);
        adc_drop = 1'b0;
        tick(3);
        check("lost_sticky", lock_lost_o, 1);
        check("lost_no_action", busy_o, 0);

        run_seq(8'd8, 8'd4, 9'd20, 0, 0, 0, 0, 1'b1);
        run_seq(8'd8, 8'd4, 9'd20, 2, 2, 2, 2, 1'b0);
        run_seq(8'd8, 8'd4, 9'd20, 3, 0, 0, 0, 1'b0);
        run_seq(8'd17, 8'd2, 9'd300, 1, 4, 3, 1, 1'b0);

        plan[0] = 0; plan[1] = 0; plan[2] = 0; plan[3] = 0;
        b_gload = n_gload; b_pload = n_pload; b_done = n_done;
        pulse_start(8'd5, 8'd6, 9'd100);
        found = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (adc_reset_o && busy_o) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        check("reach_adc_rst", found, 1);
        tick(2);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("abort_ctrl", {busy_o, done_o, error_o, err_code_o, lock_lost_o,
                             clkgen_reset_o, clkgen_load_o, adc_reset_o,
                             phase_load_o}, 32'h00A);
        check("abort_settings", {clkgen_mul_o, clkgen_div_o, phase_o}, 0);
        tick(3);
        reset_n_i = 1'b1;
        tick(20);
        check("abort_idle", busy_o, 0);
        check("abort_no_done", n_done - b_done, 0);
        check("abort_no_ph_load", n_pload - b_pload, 0);
        check("abort_one_gen_load", n_gload - b_gload, 1);

        for (int r = 0; r < 14; r++) begin
            int pl [4];
            for (int i = 0; i < 4; i++)
                pl[i] = ($urandom_range(0, 9) < 4) ? 0 : int'($urandom_range(1, 4));
            run_seq(8'($urandom), 8'($urandom), 9'($urandom),
                    pl[0], pl[1], pl[2], pl[3], 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
